regfile_param: RTL and testbench
================================

Name: regfile_param

Overview:
- Parametrised successor to the single-write-port register file used in the datapath decode/writeback stages.
- Configurable data width and register count.
- Two write ports (ALU writeback and load writeback) with defined priority.
- Optional write-to-read bypass, optional hardwired zero register.
- Multi-cycle soft-clear sequencer with busy/done handshake, so the pipeline can flush architectural state without asserting reset.

Parameters:
XLEN, 32, data width of each register in bits
NREGS, 32, number of registers (power of two, 2..256)
AW, $clog2(NREGS), index width (derived; never overridden)
ZERO_REG, 1, 1 = register 0 reads as 0 and ignores writes
BYPASS, 1, 1 = same-cycle write data is forwarded to matching read ports

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous active-low reset
RegWrite  input  1  write enable, port A
Rd  input  AW  destination index, port A
Write_data  input  XLEN  write data, port A
RegWrite2  input  1  write enable, port B
Rd2  input  AW  destination index, port B
Write_data2  input  XLEN  write data, port B
Rs1  input  AW  read index 1
Rs2  input  AW  read index 2
read_data1  output  XLEN  read data 1 (combinational)
read_data2  output  XLEN  read data 2 (combinational)
clear_req  input  1  request soft clear of all registers
clear_busy  output  1  high while the clear sweep runs
clear_done  output  1  one-cycle pulse when the sweep completes

Behaviour:
- Reset (rst=0, asynchronous): all registers = 0, FSM = IDLE, sweep pointer = 0, clear_busy = 0, clear_done = 0. No writes take effect while rst=0.
- Reads:
  - Combinational from the array.
  - Register 0 reads 0 when ZERO_REG=1.
- Writes:
  - Take effect at the rising edge when the enable is high.
  - Index 0 is discarded when ZERO_REG=1.
  - Port A and port B to the same Rd in the same cycle: port B data is stored.
- Bypass (BYPASS=1, FSM IDLE):
  - If a read index matches an enabled, effective write index in the current cycle, read data = that write data.
  - Port B takes priority over port A.
  - Never applies to index 0 when ZERO_REG=1.
  - BYPASS=0: reads return the pre-edge value; new data is visible the cycle after the write.
- Clear FSM, states IDLE, CLEAR, DONE:
  - IDLE: clear_req=1 -> CLEAR with pointer = 0. Writes in that same cycle still commit.
  - CLEAR: each cycle, the register at pointer is set to 0 and pointer increments.
    - After clearing NREGS-1 -> DONE.
    - clear_busy=1 throughout CLEAR.
    - Both write ports are ignored.
    - Bypass is disabled; reads return current array contents (partially cleared).
    - clear_req is ignored.
  - DONE: clear_done=1 and clear_busy=0 for exactly one cycle -> IDLE. Writes are accepted in DONE.
  - Total: clear_busy high for exactly NREGS cycles, starting the cycle after clear_req is sampled.
- Reset mid-sweep: immediate return to IDLE with all registers 0; no clear_done pulse.
- clear_req held high continuously: a new sweep starts on the IDLE cycle following DONE.
- Outputs clear_busy and clear_done are registered (state-decoded); there are no glitches from inputs.

Test Plan:
- Reset then read Rs1=1, Rs2=2 -> both 0. Write A: Rd=3, 0xA5A5A5A5. Next cycle, Rs1=3 -> 0xA5A5A5A5; Rs2=4 -> 0.
- ZERO_REG=1: port A writes 0xDEADBEEF to Rd=0, Rs1=0 in the same cycle and the next -> 0 both cycles. Rerun with ZERO_REG=0: next cycle reads 0xDEADBEEF.
- Dual write collision: A writes Rd=5 with 0x11111111 and B writes Rd=5 with 0x22222222 in the same cycle. With Rs1=5, BYPASS=1: same cycle -> 0x22222222; next cycle -> 0x22222222. BYPASS=0: same cycle -> old value 0.
- Soft clear (NREGS=32): fill regs 1..31 with index*0x01010101, pulse clear_req. clear_busy high for exactly 32 cycles, then clear_done high for 1 cycle. Afterwards all reads = 0. A write to Rd=7 issued during busy is lost (Rs1=7 -> 0 after done).
- Reset mid-sweep: assert rst=0 after 10 sweep cycles -> clear_busy=0 immediately and all reads 0. clear_done never pulses. After rst=1, a write to Rd=9 of 0x5 reads back 0x5 next cycle.
- Parameter sweep XLEN=64, NREGS=8: write 0xFFFF_FFFF_0000_0001 to Rd=7, read back intact. A clear sweep lasts exactly 8 busy cycles.

Source files
------------

// File: rtl/regfile_param.sv
// regfile_param: parameterised register file for the decode/writeback stages.
//   - Two write ports (A = ALU writeback, B = load writeback); B wins on a
//     same-index collision.
//   - Two combinational read ports with optional same-cycle write bypass.
//   - Optional hardwired zero register (index 0).
//   - Soft-clear sequencer: sweeps every register to zero, one per cycle,
//     so the pipeline can flush architectural state without a reset.
// Ports:
//   clk, rst (async, active low)
//   RegWrite/Rd/Write_data      write port A
//   RegWrite2/Rd2/Write_data2   write port B (priority)
//   Rs1/Rs2 -> read_data1/read_data2 (combinational)
//   clear_req -> clear_busy (NREGS cycles), clear_done (1-cycle pulse)
module regfile_param #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int AW       = $clog2(NREGS),
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            RegWrite,
  input  logic [AW-1:0]   Rd,
  input  logic [XLEN-1:0] Write_data,
  input  logic            RegWrite2,
  input  logic [AW-1:0]   Rd2,
  input  logic [XLEN-1:0] Write_data2,
  input  logic [AW-1:0]   Rs1,
  input  logic [AW-1:0]   Rs2,
  output logic [XLEN-1:0] read_data1,
  output logic [XLEN-1:0] read_data2,
  input  logic            clear_req,
  output logic            clear_busy,
  output logic            clear_done
);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_DONE} state_t;

  state_t                      r_state;
  logic [AW-1:0]               r_ptr;
  logic                        r_busy;
  logic                        r_done;
  logic [NREGS-1:0][XLEN-1:0]  r_regs;

  logic                        w_we_a;
  logic                        w_we_b;
  logic [1:0][AW-1:0]          w_rs;
  logic [1:0][XLEN-1:0]        w_rd;

  // A write is effective only outside the sweep, outside reset, and never
  // to the hardwired zero register.
  assign w_we_a = rst && RegWrite  && (r_state != S_CLEAR) &&
                  !((ZERO_REG != 0) && (Rd  == '0));
  assign w_we_b = rst && RegWrite2 && (r_state != S_CLEAR) &&
                  !((ZERO_REG != 0) && (Rd2 == '0));

  // Clear sequencer; busy/done are registered alongside the state so they
  // cannot glitch on input changes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (clear_req) begin
            r_state <= S_CLEAR;
            r_ptr   <= '0;
            r_busy  <= 1'b1;
          end
        end
        S_CLEAR: begin
          r_ptr <= r_ptr + 1'b1;
          if (r_ptr == AW'(NREGS - 1)) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  // Storage. Port B is assigned last so it wins a same-index collision.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_regs <= '0;
    end else if (r_state == S_CLEAR) begin
      r_regs[r_ptr] <= '0;
    end else begin
      if (w_we_a) r_regs[Rd]  <= Write_data;
      if (w_we_b) r_regs[Rd2] <= Write_data2;
    end
  end

  // Read ports. Bypass is IDLE-only; during the sweep reads see the
  // partially cleared array.
  assign w_rs = {Rs2, Rs1};

  always_comb begin
    w_rd = '0;
    for (int p = 0; p < 2; p++) begin
      w_rd[p] = r_regs[w_rs[p]];
      if ((BYPASS != 0) && (r_state == S_IDLE)) begin
        if (w_we_b && (Rd2 == w_rs[p]))     w_rd[p] = Write_data2;
        else if (w_we_a && (Rd == w_rs[p])) w_rd[p] = Write_data;
      end
      if ((ZERO_REG != 0) && (w_rs[p] == '0)) w_rd[p] = '0;
    end
  end

  assign read_data1 = w_rd[0];
  assign read_data2 = w_rd[1];
  assign clear_busy = r_busy;
  assign clear_done = r_done;

endmodule

// File: tb/tb_regfile_param.sv
// tb_regfile_param: drives two regfile_param configurations from shared
// stimulus (default 32x32 with zero reg + bypass, and 64x8 without either)
// and compares every cycle against a behavioural model. The sweep is
// modelled by its start cycle: busy for the NREGS cycles after it, done on
// the one after that, clearing register (cycle - start - 1) each busy cycle.
module tb_regfile_param;

  logic        clk = 1'b0;
  logic        rst;
  logic        we_a, we_b, clr;
  logic [7:0]  rd_a, rd_b, rs1, rs2;
  logic [63:0] wd_a, wd_b;
  logic [31:0] r1_0, r2_0;
  logic [63:0] r1_1, r2_1;
  logic        busy0, done0, busy1, done1;

  always #5 clk = ~clk;

  regfile_param u_rf0 (
    .clk(clk), .rst(rst),
    .RegWrite(we_a), .Rd(rd_a[4:0]), .Write_data(wd_a[31:0]),
    .RegWrite2(we_b), .Rd2(rd_b[4:0]), .Write_data2(wd_b[31:0]),
    .Rs1(rs1[4:0]), .Rs2(rs2[4:0]),
    .read_data1(r1_0), .read_data2(r2_0),
    .clear_req(clr), .clear_busy(busy0), .clear_done(done0)
  );

  regfile_param #(.XLEN(64), .NREGS(8), .ZERO_REG(0), .BYPASS(0)) u_rf1 (
    .clk(clk), .rst(rst),
    .RegWrite(we_a), .Rd(rd_a[2:0]), .Write_data(wd_a),
    .RegWrite2(we_b), .Rd2(rd_b[2:0]), .Write_data2(wd_b),
    .Rs1(rs1[2:0]), .Rs2(rs2[2:0]),
    .read_data1(r1_1), .read_data2(r2_1),
    .clear_req(clr), .clear_busy(busy1), .clear_done(done1)
  );

  // Reference model
  int          nr[2] = '{32, 8};
  bit          zr[2] = '{1'b1, 1'b0};
  bit          bp[2] = '{1'b1, 1'b0};
  logic [63:0] dm[2] = '{64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
  logic [63:0] m[2][256];
  int          sws[2];
  int          cyc;
  int          bcnt[2], dcnt[2];
  int          total = 0, bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // 0 idle, 1 sweeping, 2 done pulse
  function automatic int ph(int i);
    int d;
    if (sws[i] < 0) return 0;
    d = cyc - sws[i];
    if (d >= 1 && d <= nr[i]) return 1;
    if (d == nr[i] + 1) return 2;
    return 0;
  endfunction

  function automatic logic [63:0] exp_rd(int i, logic [7:0] idx);
    int k, ka, kb;
    k  = int'(idx)  % nr[i];
    ka = int'(rd_a) % nr[i];
    kb = int'(rd_b) % nr[i];
    if (zr[i] && k == 0) return 64'd0;
    if (bp[i] && rst && ph(i) == 0) begin
      if (we_b && kb == k) return wd_b & dm[i];
      if (we_a && ka == k) return wd_a & dm[i];
    end
    return m[i][k];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 256; k++) m[i][k] = 64'd0;
      sws[i] = -1;
    end
  endtask

  task automatic idle();
    we_a = 1'b0; we_b = 1'b0; clr = 1'b0;
  endtask

  // Called just after a rising edge with inputs set; checks mid-cycle,
  // then applies the cycle's effect to the model at the next rising edge.
  task automatic step();
    logic [63:0] o1, o2;
    logic        ob, od;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      o1 = (i == 0) ? {32'd0, r1_0} : r1_1;
      o2 = (i == 0) ? {32'd0, r2_0} : r2_1;
      ob = (i == 0) ? busy0 : busy1;
      od = (i == 0) ? done0 : done1;
      chk($sformatf("rf%0d.rd1[%0d]", i, rs1), o1, exp_rd(i, rs1));
      chk($sformatf("rf%0d.rd2[%0d]", i, rs2), o2, exp_rd(i, rs2));
      chk($sformatf("rf%0d.busy", i), {63'd0, ob}, {63'd0, ph(i) == 1});
      chk($sformatf("rf%0d.done", i), {63'd0, od}, {63'd0, ph(i) == 2});
      if (ob) bcnt[i]++;
      if (od) dcnt[i]++;
    end
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        int p, ka, kb;
        p  = ph(i);
        ka = int'(rd_a) % nr[i];
        kb = int'(rd_b) % nr[i];
        if (p == 1) begin
          m[i][cyc - sws[i] - 1] = 64'd0;
        end else begin
          if (we_a && !(zr[i] && ka == 0)) m[i][ka] = wd_a & dm[i];
          if (we_b && !(zr[i] && kb == 0)) m[i][kb] = wd_b & dm[i];
          if (p == 0 && clr) sws[i] = cyc;
        end
      end
    end
    cyc++;
    #1;
  endtask

  initial begin
    cyc = 0;
    rst = 1'b0;
    idle();
    rd_a = 8'd0; rd_b = 8'd0; wd_a = 64'd0; wd_b = 64'd0;
    rs1 = 8'd1; rs2 = 8'd2;
    model_reset();
    step(); step();
    rst = 1'b1;
    step();

    // Basic write / readback
    we_a = 1'b1; rd_a = 8'd3; wd_a = 64'hA5A5A5A5; rs1 = 8'd1; rs2 = 8'd2;
    step();
    idle(); rs1 = 8'd3; rs2 = 8'd4;
    step();
    chk("rf0.r3_readback", {32'd0, r1_0}, 64'hA5A5A5A5);

    // Write to index 0
    we_a = 1'b1; rd_a = 8'd0; wd_a = 64'hDEADBEEF; rs1 = 8'd0;
    step();
    idle();
    step();
    chk("rf1.r0_not_hardwired", r1_1, 64'hDEADBEEF);

    // Dual write collision
    we_a = 1'b1; rd_a = 8'd5; wd_a = 64'h11111111;
    we_b = 1'b1; rd_b = 8'd5; wd_b = 64'h22222222; rs1 = 8'd5;
    step();
    idle();
    step();
    chk("rf0.collision_b_wins", {32'd0, r1_0}, 64'h22222222);

    // Wide data
    we_a = 1'b1; rd_a = 8'd7; wd_a = 64'hFFFF_FFFF_0000_0001; rs1 = 8'd7;
    step();
    idle();
    step();
    chk("rf1.wide_readback", r1_1, 64'hFFFF_FFFF_0000_0001);

    // Fill then soft clear; a write issued mid-sweep is lost on rf0
    for (int r = 1; r < 32; r++) begin
      we_a = 1'b1; rd_a = 8'(r); rs1 = 8'(r); rs2 = 8'(r - 1);
      wd_a = {32'(r * 32'h01010101), 32'(r * 32'h01010101)};
      step();
    end
    idle();
    bcnt = '{0, 0}; dcnt = '{0, 0};
    clr = 1'b1;
    step();
    clr = 1'b0;
    for (int k = 0; k < 40; k++) begin
      rs1 = 8'(k % 32); rs2 = 8'd7;
      we_a = (k == 20); rd_a = 8'd7; wd_a = 64'h77;
      step();
    end
    idle();
    chk("rf0.busy_len", 64'(bcnt[0]), 64'd32);
    chk("rf1.busy_len", 64'(bcnt[1]), 64'd8);
    chk("rf0.done_cnt", 64'(dcnt[0]), 64'd1);
    chk("rf1.done_cnt", 64'(dcnt[1]), 64'd1);
    for (int r = 0; r < 32; r++) begin
      rs1 = 8'(r); rs2 = 8'd7;
      step();
    end

    // Reset in the middle of a sweep
    dcnt = '{0, 0};
    clr = 1'b1;
    step();
    clr = 1'b0;
    repeat (10) step();
    rs1 = 8'd3; rs2 = 8'd5;
    rst = 1'b0;
    model_reset();
    #1;
    chk("rf0.busy_async_rst", {63'd0, busy0}, 64'd0);
    chk("rf1.busy_async_rst", {63'd0, busy1}, 64'd0);
    chk("rf0.rd_async_rst", {32'd0, r1_0}, 64'd0);
    chk("rf1.rd_async_rst", r2_1, 64'd0);
    we_a = 1'b1; rd_a = 8'd3; wd_a = 64'h99;
    step();
    rst = 1'b1;
    we_a = 1'b1; rd_a = 8'd9; wd_a = 64'h5; rs1 = 8'd9;
    step();
    idle();
    step();
    chk("rf0.no_done_after_rst", 64'(dcnt[0]), 64'd0);
    chk("rf0.r9_after_rst", {32'd0, r1_0}, 64'h5);

    // clear_req held: back-to-back sweeps
    bcnt = '{0, 0}; dcnt = '{0, 0};
    clr = 1'b1;
    repeat (2 * 34 + 1) begin
      rs1 = 8'($urandom_range(0, 31)); rs2 = 8'($urandom_range(0, 31));
      we_a = 1'($urandom_range(0, 1)); rd_a = 8'($urandom); wd_a = {$urandom, $urandom};
      step();
    end
    idle();
    chk("rf0.held_sweeps", 64'(dcnt[0]), 64'd2);

    // Random traffic
    for (int k = 0; k < 500; k++) begin
      we_a = 1'($urandom_range(0, 1)); rd_a = 8'($urandom);
      we_b = 1'($urandom_range(0, 1)); rd_b = 8'($urandom);
      wd_a = {$urandom, $urandom};     wd_b = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) rd_b = rd_a;
      rs1 = ($urandom_range(0, 2) == 0) ? rd_a : 8'($urandom);
      rs2 = ($urandom_range(0, 2) == 0) ? rd_b : 8'($urandom_range(0, 7));
      clr = ($urandom_range(0, 39) == 0);
      step();
    end
    idle();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
